// File: rtl/gray_pkg.sv
// Shared types and constants for the gray stream controller and its converter.
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int RGB_W          = 24;
   localparam int GRAY_W         = 8;
   localparam int IMG_W_DEF      = 640;
   localparam int IMG_H_DEF      = 480;
   localparam int PIPE_LAT_DEF   = 3;
   localparam int FIFO_DEPTH_DEF = 8;

   // Counter width helper that never collapses to zero bits.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/gray_stream_ctrl_if.sv
// Pixel-in / gray-out stream bundle; slave is the controller side.
interface gray_stream_ctrl_if;
   import gray_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [RGB_W-1:0]  s_data;
   logic              m_valid;
   logic              m_ready;
   logic [GRAY_W-1:0] m_data;
   logic              m_sof;
   logic              m_eol;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_sof, m_eol
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_sof, m_eol
   );

endinterface

// File: rtl/gray_sync_fifo.sv
// Single-clock FIFO with a registered head word and full/empty flags.
module gray_sync_fifo
   import gray_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             ovf
);

   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;
   logic [AW:0]      count;
   logic [WIDTH-1:0] head;
   logic             do_rd;
   logic             do_wr;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign ovf     = wr_en & full & ~do_rd;
   assign rd_nxt  = rd_ptr + AW'(1);
   assign rd_data = head;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_nxt;
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         // New word becomes head directly when it is the only entry left.
         if (do_wr && (empty || (do_rd && count == (AW+1)'(1))))
            head <= wr_data;
         else if (do_rd && count > (AW+1)'(1))
            head <= mem[rd_nxt];
      end
   end

endmodule

// File: rtl/gray_stream_ctrl.sv
// Frame sequencer around the fixed-latency RGB-to-gray converter.
//
//   state | meaning
//   IDLE  | waiting for start, no pixels accepted
//   RUN   | admitting pixels against FIFO credits until the frame is in
//   DRAIN | frame fully admitted, emptying results until the last pop
module gray_stream_ctrl
   import gray_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int PIPE_LAT   = PIPE_LAT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              err_ovf,
   gray_stream_ctrl_if.slave bus,
   output logic              dp_valid_o,
   output logic [RGB_W-1:0]  dp_data_o,
   input  logic              dp_valid_i,
   input  logic [GRAY_W-1:0] dp_data_i
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = clog2_min1(NPIX + 1);
   localparam int XW   = clog2_min1(IMG_W);
   localparam int YW   = clog2_min1(IMG_H);
   localparam int RW   = clog2_min1(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] NPIX_C  = CW'(NPIX);
   localparam logic [RW-1:0] DEPTH_C = RW'(FIFO_DEPTH);
   localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

   if ((FIFO_DEPTH < PIPE_LAT + 3) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
      $error("gray_stream_ctrl: FIFO_DEPTH must be a power of 2 and >= PIPE_LAT+3");
   end

   state_t            state;
   logic [CW-1:0]     in_cnt;
   logic [RW-1:0]     reserved;
   logic [XW-1:0]     out_x;
   logic [YW-1:0]     out_y;
   logic              accept;
   logic              pop;
   logic              last_out;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_ovf;
   logic [GRAY_W-1:0] fifo_q;

   // Admission depends only on registered state, never on s_valid/m_ready.
   assign bus.s_ready = (state == RUN) && (reserved < DEPTH_C) && (in_cnt < NPIX_C);
   assign accept      = bus.s_valid & bus.s_ready;
   assign bus.m_valid = ~fifo_empty;
   assign pop         = bus.m_valid & bus.m_ready;
   assign last_out    = (out_x == X_LAST) && (out_y == Y_LAST);
   assign frame_done  = (state == DRAIN) && pop && last_out;
   assign busy        = (state != IDLE);
   assign bus.m_data  = fifo_q;
   assign bus.m_sof   = (out_x == '0) && (out_y == '0) && bus.m_valid;
   assign bus.m_eol   = (out_x == X_LAST) && bus.m_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         in_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  in_cnt <= '0;
               end
            end
            RUN: begin
               if (accept) in_cnt <= in_cnt + CW'(1);
               if (in_cnt == NPIX_C) state <= DRAIN;
            end
            DRAIN: begin
               if (frame_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reserved <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   reserved <= reserved + RW'(1);
            2'b01:   reserved <= reserved - RW'(1);
            default: reserved <= reserved;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dp_valid_o <= 1'b0;
         dp_data_o  <= '0;
      end else begin
         dp_valid_o <= accept;
         if (accept) dp_data_o <= bus.s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_x   <= '0;
         out_y   <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (fifo_ovf) err_ovf <= 1'b1;
         if (frame_done) begin
            out_x <= '0;
            out_y <= '0;
         end else if (pop) begin
            if (out_x == X_LAST) begin
               out_x <= '0;
               out_y <= out_y + YW'(1);
            end else begin
               out_x <= out_x + XW'(1);
            end
         end
      end
   end

   gray_sync_fifo #(
      .WIDTH (GRAY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (dp_valid_i),
      .wr_data (dp_data_i),
      .rd_en   (pop),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .ovf     (fifo_ovf)
   );

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_gray_stream_ctrl.sv
// Directed bench for gray_stream_ctrl on a 4x2 frame with a behavioural converter.
module tb_gray_stream_ctrl;
   import gray_pkg::*;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int LAT   = 3;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic        err_ovf;
   logic        dp_valid_o;
   logic [23:0] dp_data_o;
   logic        dp_valid_i;
   logic [7:0]  dp_data_i;

   always #5 clk = ~clk;

   gray_stream_ctrl_if bus ();

   gray_stream_ctrl #(
      .IMG_W (W), .IMG_H (H), .PIPE_LAT (LAT), .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .err_ovf    (err_ovf),
      .bus        (bus),
      .dp_valid_o (dp_valid_o),
      .dp_data_o  (dp_data_o),
      .dp_valid_i (dp_valid_i),
      .dp_data_i  (dp_data_i)
   );

   function automatic logic [7:0] ref_gray(input logic [23:0] p);
      logic [31:0] s;
      s = 32'd77 * p[23:16] + 32'd150 * p[15:8] + 32'd29 * p[7:0];
      return s[15:8];
   endfunction

   function automatic logic [23:0] pix(input int k);
      logic [31:0] h;
      h = k * 32'h9E3779B1 + 32'h01234567;
      return h[31:8];
   endfunction

   // Converter model: fixed latency, shares clk and reset.
   logic [LAT-1:0] pipe_v;
   logic [7:0]     pipe_d [LAT];
   always @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
      end else begin
         pipe_v    <= {pipe_v[LAT-2:0], dp_valid_o};
         pipe_d[0] <= ref_gray(dp_data_o);
         for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign dp_valid_i = pipe_v[LAT-1];
   assign dp_data_i  = pipe_d[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [23:0] acc_q [$];
   int          acc_cyc [$];
   logic [7:0]  out_q [$];
   bit          sof_q [$];
   bit          eol_q [$];
   bit          fd_q [$];
   int          out_cyc [$];
   int          fd_cnt;
   int          dpv_cnt;

   always @(negedge clk) begin
      if (bus.s_valid && bus.s_ready) begin
         acc_q.push_back(bus.s_data);
         acc_cyc.push_back(cyc);
      end
      if (bus.m_valid && bus.m_ready) begin
         out_q.push_back(bus.m_data);
         sof_q.push_back(bus.m_sof);
         eol_q.push_back(bus.m_eol);
         fd_q.push_back(frame_done);
         out_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
      if (dp_valid_o) dpv_cnt++;
   end

   int checks   = 0;
   int failures = 0;
   int next_idx = 0;
   bit fd_now;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      acc_q.delete(); acc_cyc.delete(); out_q.delete(); sof_q.delete();
      eol_q.delete(); fd_q.delete(); out_cyc.delete();
      fd_cnt = 0; dpv_cnt = 0;
   endtask

   function automatic logic [31:0] pack_bits(input bit q [$]);
      logic [31:0] v = '0;
      for (int j = 0; j < q.size() && j < 32; j++) v[j] = q[j];
      return v;
   endfunction

   function automatic int data_mism();
      int m = 0;
      for (int j = 0; j < out_q.size(); j++)
         if (j >= acc_q.size() || out_q[j] !== ref_gray(acc_q[j])) m++;
      return m;
   endfunction

   // Entered and left at posedge+1; outputs observed at the negedge in between.
   task automatic drive_cycle(input bit sv, input bit mr, input bit st);
      bus.s_valid = sv;
      bus.m_ready = mr;
      bus.s_data  = pix(next_idx);
      start       = st;
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) next_idx++;
      fd_now = frame_done;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int pv, input int pr, input int budget, output bit done);
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         drive_cycle($urandom_range(99) < pv, $urandom_range(99) < pr, 1'b0);
         if (fd_now) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},   busy,         0);
      check({tag, "_fdone"},  frame_done,   0);
      check({tag, "_ovf"},    err_ovf,      0);
      check({tag, "_sready"}, bus.s_ready,  0);
      check({tag, "_dpv"},    dp_valid_o,   0);
      check({tag, "_mvalid"}, bus.m_valid,  0);
      check({tag, "_sof"},    bus.m_sof,    0);
      check({tag, "_eol"},    bus.m_eol,    0);
      check({tag, "_dpdata"}, dp_data_o,    0);
      check({tag, "_mdata"},  bus.m_data,   0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          done;
      bit          d2;
      logic [7:0]  hold1;
      int          tot_out, tot_mis, tot_sof, tot_eol, frames_ok, n;

      reset = 1'b1; start = 1'b0;
      bus.s_valid = 1'b0; bus.m_ready = 1'b0; bus.s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_zero("rst");

      // s_valid while IDLE must not be admitted
      clear_rec();
      repeat (5) drive_cycle(1'b1, 1'b1, 1'b0);
      check("idle_acc", acc_q.size(), 0);
      check("idle_dpv", dpv_cnt, 0);

      // full-rate frame
      clear_rec();
      drive_cycle(1'b0, 1'b1, 1'b1);
      run_frame(100, 100, 100, done);
      check("f1_done",  done, 1);
      check("f1_count", out_q.size(), 8);
      check("f1_data",  data_mism(), 0);
      check("f1_sof",   pack_bits(sof_q), 32'h01);
      check("f1_eol",   pack_bits(eol_q), 32'h88);
      check("f1_fdone", pack_bits(fd_q), 32'h80);
      check("f1_lat",   out_cyc[0] - acc_cyc[0], 5);
      check("f1_rate",  out_cyc[7] - out_cyc[0], 7);
      check("f1_fdcnt", fd_cnt, 1);
      check("f1_busy",  busy, 0);

      // stall downstream, with start pulses in RUN and in DRAIN
      clear_rec();
      drive_cycle(1'b0, 1'b0, 1'b1);
      repeat (2) drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1);
      repeat (8) drive_cycle(1'b1, 1'b0, 1'b0);
      hold1 = bus.m_data;
      drive_cycle(1'b1, 1'b0, 1'b1);
      repeat (5) drive_cycle(1'b1, 1'b0, 1'b0);
      check("st_acc",    acc_q.size(), 8);
      check("st_sready", bus.s_ready, 0);
      check("st_ovf",    err_ovf, 0);
      check("st_mvalid", bus.m_valid, 1);
      check("st_hold1",  hold1, ref_gray(acc_q[0]));
      check("st_hold2",  bus.m_data, ref_gray(acc_q[0]));
      check("st_nopop",  out_q.size(), 0);
      run_frame(100, 100, 100, done);
      check("st_done",  done, 1);
      check("st_count", out_q.size(), 8);
      check("st_data",  data_mism(), 0);
      check("st_fdcnt", fd_cnt, 1);
      check("st_busy",  busy, 0);

      // random valid/ready over several frames
      tot_out = 0; tot_mis = 0; tot_sof = 0; tot_eol = 0; frames_ok = 0;
      for (int f = 0; f < 6; f++) begin
         clear_rec();
         drive_cycle(1'b0, 1'b1, 1'b1);
         run_frame(70, 50, 400, done);
         if (done) frames_ok++;
         tot_out += out_q.size();
         tot_mis += data_mism();
         foreach (sof_q[j]) tot_sof += int'(sof_q[j]);
         foreach (eol_q[j]) tot_eol += int'(eol_q[j]);
      end
      check("rnd_frames", frames_ok, 6);
      check("rnd_count",  tot_out, 48);
      check("rnd_data",   tot_mis, 0);
      check("rnd_sof",    tot_sof, 6);
      check("rnd_eol",    tot_eol, 12);
      check("rnd_ovf",    err_ovf, 0);

      // reset in the middle of a frame
      clear_rec();
      drive_cycle(1'b0, 1'b0, 1'b1);
      n = 0;
      while (acc_q.size() < 5 && n < 50) begin
         drive_cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      check("mr_acc", acc_q.size(), 5);
      reset = 1'b1;
      drive_cycle(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check_zero("mr");
      clear_rec();
      repeat (6) drive_cycle(1'b0, 1'b1, 1'b0);
      check("mr_stale", out_q.size(), 0);
      drive_cycle(1'b0, 1'b1, 1'b1);
      run_frame(100, 100, 100, done);
      check("mr_done",  done, 1);
      check("mr_count", out_q.size(), 8);
      check("mr_sof",   pack_bits(sof_q), 32'h01);
      check("mr_data",  data_mism(), 0);

      // back-to-back frames, start the cycle after frame_done
      clear_rec();
      drive_cycle(1'b0, 1'b1, 1'b1);
      run_frame(100, 100, 100, done);
      drive_cycle(1'b1, 1'b1, 1'b1);
      run_frame(100, 100, 100, d2);
      check("bb_done1", done, 1);
      check("bb_done2", d2, 1);
      check("bb_count", out_q.size(), 16);
      check("bb_sof",   pack_bits(sof_q), 32'h0101);
      check("bb_eol",   pack_bits(eol_q), 32'h8888);
      check("bb_data",  data_mism(), 0);
      check("bb_lat2",  out_cyc[8] - acc_cyc[8], 5);
      check("bb_fdcnt", fd_cnt, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
